ifetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Accepts the current PC, issues a word read to instruction memory over a valid/ready request channel, and captures the response.
- Presents {instruction, pc, error} to decode through a 2-entry output FIFO.
- Back-pressures the PC through o_pc_ready, the PC advance enable, and discards in-flight fetches when a taken branch flushes the pipe.

---
 rtl/ifetch_pkg.sv | 31 +++
 rtl/ifetch_fifo.sv | 71 +++++++
 rtl/ifetch_unit.sv | 147 ++++++++++++++
 tb/tb_ifetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int IF_ADDR_W = 32;
  localparam int IF_DATA_W = 32;

  // Canonical NOP (addi x0, x0, 0) used as filler for error entries.
  localparam logic [IF_DATA_W-1:0] NOP_INST_WORD = 32'h0000_0013;

  // Error codes reported alongside each fetched instruction.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS      = 2'b10;

  // Fetch sequencing states; the KILL variants wait out a flushed transaction.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT      = 3'd2,
    REQ_KILL  = 3'd3,
    WAIT_KILL = 3'd4
  } fetch_state_t;

  // One decoded-side entry; field order matches the packed FIFO word.
  typedef struct packed {
    logic [IF_DATA_W-1:0] inst;
    logic [IF_ADDR_W-1:0] pc;
    logic [1:0]           err;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with a flush that empties it on the next edge.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 66,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_pop;
  logic             do_push;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem[rd_ptr];

  // A pop frees the head slot, so a full FIFO may still accept a push alongside it.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage, pointers and occupancy; flush discards everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding memory read, results queued for decode.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [DATA_W-1:0] NOP_INST   = DATA_W'(NOP_INST_WORD)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pc_valid,
  output logic              o_pc_ready,
  input  logic              i_flush,
  output logic              o_imem_req_valid,
  output logic [ADDR_W-1:0] o_imem_req_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [DATA_W-1:0] i_imem_rsp_data,
  input  logic              i_imem_rsp_err,
  output logic              o_inst_valid,
  output logic [DATA_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic [1:0]        o_inst_err,
  input  logic              i_inst_ready
);

  localparam int              ENTRY_W   = DATA_W + ADDR_W + 2;
  localparam int              CNT_W     = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;

  logic              accept;
  logic              misaligned;
  logic              push;
  logic [ENTRY_W-1:0] push_data;
  logic              pop;
  logic [ENTRY_W-1:0] head_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // PC handshake: only idle, unflushed, with room left for the eventual result.
  always_comb begin
    o_pc_ready = i_rst && (state == IDLE) && !i_flush && (fifo_count < DEPTH_CNT);
    accept     = i_pc_valid && o_pc_ready;
    misaligned = (i_pc[1:0] != 2'b00);
  end

  // Select what enters the FIFO: misaligned-PC filler or a live memory response.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (!i_flush) begin
      if (accept && misaligned) begin
        push      = 1'b1;
        push_data = {NOP_INST, i_pc, ERR_MISALIGN};
      end else if ((state == WAIT) && i_imem_rsp_valid && !fifo_full) begin
        push      = 1'b1;
        push_data = {i_imem_rsp_data, pc_q, (i_imem_rsp_err ? ERR_BUS : ERR_NONE)};
      end
    end
  end

  assign pop = i_inst_ready && !fifo_empty;

  // Fetch sequencer; request outputs are registered and never withdrawn once raised.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      pc_q        <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !misaligned) begin
            pc_q        <= i_pc;
            req_valid_q <= 1'b1;
            req_addr_q  <= {i_pc[ADDR_W-1:2], 2'b00};
            state       <= REQ;
          end
        end
        REQ: begin
          if (i_imem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= i_flush ? WAIT_KILL : WAIT;
          end else if (i_flush) begin
            state <= REQ_KILL;
          end
        end
        WAIT: begin
          if (i_imem_rsp_valid) begin
            state <= IDLE;
          end else if (i_flush) begin
            state <= WAIT_KILL;
          end
        end
        REQ_KILL: begin
          if (i_imem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= WAIT_KILL;
          end
        end
        WAIT_KILL: begin
          if (i_imem_rsp_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign o_imem_req_valid = req_valid_q;
  assign o_imem_req_addr  = req_addr_q;

  ifetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .flush     (i_flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_inst_valid = !fifo_empty;
  assign o_inst       = head_data[ENTRY_W-1 -: DATA_W];
  assign o_inst_pc    = head_data[ADDR_W+1 -: ADDR_W];
  assign o_inst_err   = head_data[1:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for the instruction fetch stage.
module tb_ifetch_unit;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_pc;
  logic        i_pc_valid;
  logic        o_pc_ready;
  logic        i_flush;
  logic        o_imem_req_valid;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_req_ready;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_imem_rsp_err;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic [1:0]  o_inst_err;
  logic        i_inst_ready;

  int test_count;
  int fail_count;

  ifetch_unit dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_pc             (i_pc),
    .i_pc_valid       (i_pc_valid),
    .o_pc_ready       (o_pc_ready),
    .i_flush          (i_flush),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_imem_rsp_err   (i_imem_rsp_err),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .o_inst_err       (o_inst_err),
    .i_inst_ready     (i_inst_ready)
  );

  // Free-running 10-unit clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Compare one observed value against its expected value and log any difference.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Zero-wait fetch of one aligned PC; the result lands at the FIFO tail.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data, input logic err);
    i_pc             = pc;
    i_pc_valid       = 1'b1;
    i_imem_req_ready = 1'b1;
    step();
    i_pc_valid = 1'b0;
    step();
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = data;
    i_imem_rsp_err   = err;
    step();
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_err   = 1'b0;
  endtask

  // Consume the head entry.
  task automatic popEntry();
    i_inst_ready = 1'b1;
    step();
    i_inst_ready = 1'b0;
  endtask

  // Directed scenario sequence.
  initial begin
    test_count       = 0;
    fail_count       = 0;
    i_rst            = 1'b0;
    i_pc             = '0;
    i_pc_valid       = 1'b0;
    i_flush          = 1'b0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_imem_rsp_err   = 1'b0;
    i_inst_ready     = 1'b0;

    #3;
    checkOutput("rst_req_valid", 64'(o_imem_req_valid), 64'd0);
    checkOutput("rst_req_addr", 64'(o_imem_req_addr), 64'd0);
    checkOutput("rst_inst_valid", 64'(o_inst_valid), 64'd0);
    checkOutput("rst_inst", 64'(o_inst), 64'd0);
    checkOutput("rst_inst_pc", 64'(o_inst_pc), 64'd0);
    checkOutput("rst_inst_err", 64'(o_inst_err), 64'd0);
    checkOutput("rst_pc_ready", 64'(o_pc_ready), 64'd0);
    step();
    step();
    i_rst = 1'b1;
    step();

    // Basic zero-wait fetch with cycle-accurate latency.
    i_pc             = 32'h0000_0000;
    i_pc_valid       = 1'b1;
    i_imem_req_ready = 1'b1;
    #1;
    checkOutput("t1_pc_ready", 64'(o_pc_ready), 64'd1);
    step();
    i_pc_valid = 1'b0;
    checkOutput("t1_req_valid", 64'(o_imem_req_valid), 64'd1);
    checkOutput("t1_req_addr", 64'(o_imem_req_addr), 64'h0);
    step();
    checkOutput("t1_req_dropped", 64'(o_imem_req_valid), 64'd0);
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'h0050_0093;
    checkOutput("t1_not_yet_valid", 64'(o_inst_valid), 64'd0);
    step();
    i_imem_rsp_valid = 1'b0;
    checkOutput("t1_inst_valid", 64'(o_inst_valid), 64'd1);
    checkOutput("t1_inst", 64'(o_inst), 64'h0050_0093);
    checkOutput("t1_inst_pc", 64'(o_inst_pc), 64'h0);
    checkOutput("t1_inst_err", 64'(o_inst_err), 64'd0);
    popEntry();
    checkOutput("t1_popped", 64'(o_inst_valid), 64'd0);

    // Request held stable while memory stalls.
    i_imem_req_ready = 1'b0;
    i_pc             = 32'h0000_0010;
    i_pc_valid       = 1'b1;
    step();
    i_pc_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_hold_valid", 64'(o_imem_req_valid), 64'd1);
      checkOutput("t2_hold_addr", 64'(o_imem_req_addr), 64'h10);
      checkOutput("t2_hold_pc_ready", 64'(o_pc_ready), 64'd0);
      step();
    end
    i_imem_req_ready = 1'b1;
    step();
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'h0000_0113;
    step();
    i_imem_rsp_valid = 1'b0;
    checkOutput("t2_inst_pc", 64'(o_inst_pc), 64'h10);
    checkOutput("t2_inst", 64'(o_inst), 64'h0000_0113);
    popEntry();

    // Misaligned PC produces a filler entry without touching memory.
    i_pc       = 32'h0000_0006;
    i_pc_valid = 1'b1;
    step();
    i_pc_valid = 1'b0;
    checkOutput("t3_no_req", 64'(o_imem_req_valid), 64'd0);
    checkOutput("t3_inst_valid", 64'(o_inst_valid), 64'd1);
    checkOutput("t3_inst", 64'(o_inst), 64'h0000_0013);
    checkOutput("t3_inst_pc", 64'(o_inst_pc), 64'h6);
    checkOutput("t3_inst_err", 64'(o_inst_err), 64'd1);
    popEntry();

    // FIFO fills to two entries and blocks the third PC until a pop.
    applyStimulus(32'h0, 32'hAAAA_0001, 1'b0);
    applyStimulus(32'h4, 32'hAAAA_0002, 1'b0);
    i_pc       = 32'h8;
    i_pc_valid = 1'b1;
    #1;
    checkOutput("t4_full_pc_ready", 64'(o_pc_ready), 64'd0);
    step();
    checkOutput("t4_no_accept", 64'(o_imem_req_valid), 64'd0);
    checkOutput("t4_head_pc", 64'(o_inst_pc), 64'h0);
    i_inst_ready = 1'b1;
    step();
    i_inst_ready = 1'b0;
    #1;
    checkOutput("t4_room_pc_ready", 64'(o_pc_ready), 64'd1);
    checkOutput("t4_head_after_pop", 64'(o_inst_pc), 64'h4);
    step();
    i_pc_valid = 1'b0;
    checkOutput("t4_req_valid", 64'(o_imem_req_valid), 64'd1);
    checkOutput("t4_req_addr", 64'(o_imem_req_addr), 64'h8);
    step();
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'hAAAA_0003;
    step();
    i_imem_rsp_valid = 1'b0;
    checkOutput("t4_head_still_4", 64'(o_inst), 64'hAAAA_0002);
    popEntry();
    checkOutput("t4_tail_pc", 64'(o_inst_pc), 64'h8);
    checkOutput("t4_tail_inst", 64'(o_inst), 64'hAAAA_0003);
    popEntry();

    // Flush during WAIT drops the queued entry and the late response.
    i_pc       = 32'h2;
    i_pc_valid = 1'b1;
    step();
    i_pc       = 32'h40;
    step();
    i_pc_valid = 1'b0;
    checkOutput("t5_pre_queued", 64'(o_inst_valid), 64'd1);
    step();
    i_flush = 1'b1;
    #1;
    checkOutput("t5_flush_pc_ready", 64'(o_pc_ready), 64'd0);
    step();
    i_flush = 1'b0;
    checkOutput("t5_flushed_empty", 64'(o_inst_valid), 64'd0);
    step();
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    i_imem_rsp_valid = 1'b0;
    checkOutput("t5_rsp_dropped", 64'(o_inst_valid), 64'd0);
    checkOutput("t5_back_idle", 64'(o_pc_ready), 64'd1);
    applyStimulus(32'h44, 32'h1111_1111, 1'b0);
    checkOutput("t5_next_inst", 64'(o_inst), 64'h1111_1111);
    checkOutput("t5_next_pc", 64'(o_inst_pc), 64'h44);
    popEntry();

    // Bus error response is tagged.
    applyStimulus(32'h20, 32'hCAFE_F00D, 1'b1);
    checkOutput("t6_err", 64'(o_inst_err), 64'd2);
    checkOutput("t6_pc", 64'(o_inst_pc), 64'h20);
    checkOutput("t6_inst", 64'(o_inst), 64'hCAFE_F00D);
    popEntry();

    // Highest word address fetches normally.
    applyStimulus(32'hFFFF_FFFC, 32'h0000_006F, 1'b0);
    checkOutput("t7_top_pc", 64'(o_inst_pc), 64'hFFFF_FFFC);
    checkOutput("t7_top_err", 64'(o_inst_err), 64'd0);

    // Asynchronous reset in the middle of a WAIT, with an entry still queued.
    i_pc       = 32'h80;
    i_pc_valid = 1'b1;
    step();
    i_pc_valid = 1'b0;
    step();
    checkOutput("t8_pre_addr", 64'(o_imem_req_addr), 64'h80);
    #1;
    i_rst = 1'b0;
    #1;
    checkOutput("t8_req_addr", 64'(o_imem_req_addr), 64'd0);
    checkOutput("t8_req_valid", 64'(o_imem_req_valid), 64'd0);
    checkOutput("t8_inst_valid", 64'(o_inst_valid), 64'd0);
    checkOutput("t8_inst", 64'(o_inst), 64'd0);
    checkOutput("t8_inst_pc", 64'(o_inst_pc), 64'd0);
    checkOutput("t8_pc_ready", 64'(o_pc_ready), 64'd0);
    step();
    i_rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
